// File: rtl/matrix_mac_sequencer.sv
// 2x2 matrix multiplier: operator loads A and B through a debounced key, then
// C = A*B is computed on one shared multiply-accumulate unit, one product per cycle.
module matrix_mac_sequencer #(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key1,
   input  logic [9:0]       SW,
   output logic [9:0]       LED,
   output logic [WIDTH-1:0] c00,
   output logic [WIDTH-1:0] c01,
   output logic [WIDTH-1:0] c10,
   output logic [WIDTH-1:0] c11
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {LOAD, COMP, DONE} state_t;

   logic          key_s1, key_s2, key_acc, press;
   logic [CW-1:0] db_cnt;
   logic          abort_s1, abort_s2;

   state_t                   state;
   logic [2:0]               idx, step;
   logic [WIDTH-1:0]         acc;
   logic [7:0][WIDTH-1:0]    mat;   // A00 A01 A10 A11 B00 B01 B10 B11
   logic                     busy, done;

   logic [2:0]               a_sel, b_sel;
   logic [2*WIDTH-1:0]       prod_full;
   logic [WIDTH-1:0]         prod, sum;
   logic                     unused_sw;

   assign unused_sw = ^SW[8:0];

   // key1 synchronizer and debouncer; press fires once per accepted 1->0 change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_s1  <= 1'b1;
         key_s2  <= 1'b1;
         key_acc <= 1'b1;
         db_cnt  <= '0;
         press   <= 1'b0;
      end else begin
         key_s1 <= key1;
         key_s2 <= key_s1;
         press  <= 1'b0;
         if (key_s2 == key_acc) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt  <= '0;
            key_acc <= key_s2;
            press   <= ~key_s2;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         abort_s1 <= 1'b0;
         abort_s2 <= 1'b0;
      end else begin
         abort_s1 <= SW[9];
         abort_s2 <= abort_s1;
      end
   end

   // step = {i, j, t}: A row i column t, B row t column j
   always_comb begin
      a_sel     = {1'b0, step[2], step[0]};
      b_sel     = {1'b1, step[0], step[1]};
      prod_full = mat[a_sel] * mat[b_sel];
      prod      = prod_full[WIDTH-1:0];
      sum       = acc + prod;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= LOAD;
         idx   <= '0;
         step  <= '0;
         acc   <= '0;
         mat   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         c00   <= '0;
         c01   <= '0;
         c10   <= '0;
         c11   <= '0;
      end else if (abort_s2) begin
         state <= LOAD;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         c00   <= '0;
         c01   <= '0;
         c10   <= '0;
         c11   <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (press) begin
                  mat[idx] <= SW[WIDTH-1:0];
                  if (idx == 3'd7) begin
                     state <= COMP;
                     step  <= '0;
                     busy  <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            COMP: begin
               if (!step[0]) begin
                  acc <= prod;
               end else begin
                  acc <= sum;
                  case (step[2:1])
                     2'd0:    c00 <= sum;
                     2'd1:    c01 <= sum;
                     2'd2:    c10 <= sum;
                     default: c11 <= sum;
                  endcase
               end
               if (step == 3'd7) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  step <= step + 1'b1;
               end
            end
            DONE: begin
               if (press) begin
                  state <= LOAD;
                  idx   <= '0;
                  done  <= 1'b0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign LED = {done, busy, 4'b0000, idx[2], idx};

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: loads matrices through the bouncing key path
// and compares results and cycle timing against a plain 2x2 matrix product.
module tb_matrix_mac_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       key1;
   logic [9:0] SW;
   logic [9:0] LED;
   logic [7:0] c00, c01, c10, c11;

   int checks = 0;
   int errors = 0;

   int ma[4], mb[4], exp_c[4];
   bit in_done = 0;

   matrix_mac_sequencer #(.WIDTH(8), .DB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .key1(key1), .SW(SW), .LED(LED),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dut_c(input int n);
      case (n)
         0:       return c00;
         1:       return c01;
         2:       return c10;
         default: return c11;
      endcase
   endfunction

   function automatic logic [63:0] mk(input int a00, a01, a10, a11, b00, b01, b10, b11);
      logic [7:0][7:0] m;
      m = {8'(b11), 8'(b10), 8'(b01), 8'(b00), 8'(a11), 8'(a10), 8'(a01), 8'(a00)};
      return m;
   endfunction

   // C[i][j] = sum_t A[i][t]*B[t][j], modulo 256
   task automatic model_compute();
      for (int e = 0; e < 4; e++) begin
         int i, j;
         i = e / 2;
         j = e % 2;
         exp_c[e] = (ma[2*i] * mb[j] + ma[2*i+1] * mb[2+j]) % 256;
      end
   endtask

   task automatic check_results(input string tag);
      for (int e = 0; e < 4; e++)
         check($sformatf("%s c%0d", tag, e), 32'(dut_c(e)), 32'(exp_c[e]));
   endtask

   task automatic press_key(input logic [7:0] val);
      @(negedge clk);
      SW[7:0] = val;
      key1 = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      key1 = 1'b1;
      repeat (8) @(posedge clk);
   endtask

   // Final press (B11) with per-cycle schedule checks; mode 1 pulls reset at E+4.
   task automatic final_press(input logic [7:0] val, input int mode, input string tag);
      int n;
      int old_c[4];
      bit seen;
      seen = 0;
      old_c = exp_c;
      model_compute();
      @(negedge clk);
      SW[7:0] = val;
      key1 = 1'b0;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (LED[8] === 1'b1) begin
            seen = 1;
            break;
         end
      end
      check({tag, " busy rise"}, 32'(seen), 32'd1);
      if (!seen) begin
         key1 = 1'b1;
         return;
      end
      check({tag, " press latency"}, 32'(n >= 5 && n <= 8), 32'd1);
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) key1 = 1'b1;
         for (int e = 0; e < 4; e++)
            check($sformatf("%s E+%0d c%0d", tag, k, e), 32'(dut_c(e)),
                  32'((k >= 2*(e+1)) ? exp_c[e] : old_c[e]));
         check($sformatf("%s E+%0d busy", tag, k), 32'(LED[8]), 32'(k < 8));
         check($sformatf("%s E+%0d done", tag, k), 32'(LED[9]), 32'(k == 8));
         if (mode == 1 && k == 4) begin
            rst = 1'b0;
            #1;
            for (int e = 0; e < 4; e++) begin
               exp_c[e] = 0;
               ma[e] = 0;
               mb[e] = 0;
            end
            check_results({tag, " after reset"});
            check({tag, " LED after reset"}, 32'(LED), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            in_done = 0;
            repeat (3) @(negedge clk);
            return;
         end
      end
      in_done = 1;
      repeat (4) @(negedge clk);
   endtask

   task automatic load_mats(input logic [63:0] mp, input int start, input int mode, input string tag);
      logic [7:0][7:0] m;
      m = mp;
      if (in_done) begin
         press_key(8'h00);
         in_done = 0;
         check({tag, " leave DONE"}, 32'({LED[9:8], LED[2:0]}), 32'd0);
      end
      for (int e = 0; e < 4; e++) begin
         ma[e] = int'(m[e]);
         mb[e] = int'(m[4+e]);
      end
      for (int e = start; e < 7; e++) begin
         press_key(m[e]);
         check($sformatf("%s idx %0d", tag, e + 1), 32'(LED[3:0]),
               32'((e + 1) | ((e + 1 >= 4) ? 8 : 0)));
      end
      final_press(m[7], mode, tag);
   endtask

   initial begin
      logic [7:0][7:0] m;
      logic [7:0] a00v;
      rst  = 1'b0;
      key1 = 1'b1;
      SW   = '0;
      repeat (3) @(negedge clk);
      check("reset LED", 32'(LED), 32'd0);
      for (int e = 0; e < 4; e++) exp_c[e] = 0;
      check_results("reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // bounces shorter than the debounce window must not capture
      SW[7:0] = 8'd4;
      for (int p = 0; p < 10; p++) begin
         key1 = 1'b0;
         repeat (3) @(negedge clk);
         key1 = 1'b1;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("bounce idx", 32'(LED[3:0]), 32'd0);
      key1 = 1'b0;
      repeat (6) @(negedge clk);
      key1 = 1'b1;
      repeat (8) @(negedge clk);
      check("long press idx", 32'(LED[3:0]), 32'd1);

      // base multiply: A00=4 already captured
      load_mats(mk(4, 5, 2, 6, 1, 3, 7, 2), 1, 0, "base");
      check("base c00", 32'(c00), 32'd39);
      check("base c01", 32'(c01), 32'd22);
      check("base c10", 32'(c10), 32'd44);
      check("base c11", 32'(c11), 32'd18);

      load_mats(mk(15, 15, 15, 15, 15, 15, 15, 15), 0, 0, "ovf15");
      check("ovf15 c00", 32'(c00), 32'd194);
      load_mats(mk(16, 16, 16, 16, 16, 16, 16, 16), 0, 0, "ovf16");
      check("ovf16 c11", 32'(c11), 32'd0);

      for (int r = 0; r < 3; r++)
         load_mats({$urandom, $urandom}, 0, 0, $sformatf("rand%0d", r));

      // press arriving while the last product is in flight is dropped
      m = mk(4, 5, 2, 6, 1, 3, 7, 2);
      press_key(8'h00);
      in_done = 0;
      for (int e = 0; e < 4; e++) begin
         ma[e] = int'(m[e]);
         mb[e] = int'(m[4+e]);
      end
      for (int e = 0; e < 7; e++) press_key(m[e]);
      model_compute();
      @(negedge clk);
      SW[7:0] = m[7];
      key1 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      key1 = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      key1 = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      key1 = 1'b1;
      check("comp press E+7 busy", 32'(LED[8]), 32'd1);
      @(negedge clk);
      check("comp press E+8 done", 32'(LED[9]), 32'd1);
      check_results("comp press");
      repeat (10) @(negedge clk);
      check("comp press still done", 32'(LED[9]), 32'd1);
      check_results("comp press held");
      in_done = 1;

      // abort in DONE, with a press while abort is held
      @(negedge clk);
      SW[9] = 1'b1;
      repeat (4) @(negedge clk);
      for (int e = 0; e < 4; e++) exp_c[e] = 0;
      check_results("abort");
      check("abort LED", 32'(LED), 32'd0);
      press_key(8'h55);
      check("abort press LED", 32'(LED), 32'd0);
      SW[9] = 1'b0;
      repeat (4) @(negedge clk);
      in_done = 0;
      m = {$urandom, $urandom};
      load_mats(mk(4, 5, 2, 6, m[4], m[5], m[6], m[7]), 0, 0, "reload");

      // reset mid-compute, then a fresh load starting at A00
      load_mats({$urandom, $urandom}, 0, 1, "rstmid");
      a00v = 8'($urandom);
      press_key(a00v);
      check("post reset idx", 32'(LED[3:0]), 32'd1);
      m = {$urandom, $urandom};
      m[0] = a00v;
      load_mats(m, 1, 0, "post reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
